pc_fetch_unit: RTL
==================

PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, address of the first instruction fetched after reset.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 imem_req  output  1  fetch request to instruction memory.
REQ-005 imem_addr  output  32  fetch byte address.
REQ-006 imem_rvalid  input  1  instruction memory returns data this cycle.
REQ-007 imem_rdata  input  32  returned instruction word.
REQ-008 instr  output  32  held instruction; opcode field instr[6:0] feeds the control unit.
REQ-009 instr_valid  output  1  instr and pc are valid for execution.
REQ-010 instr_ready  input  1  datapath retires the current instruction this cycle.
REQ-011 pc  output  32  address of the instruction presented on instr.
REQ-012 pc_plus4  output  32  pc + 4, used as the link value by JAL/JALR.
REQ-013 Branch, Jump, Jalr  input  1 each  control-unit decode of the current instruction.
REQ-014 zero  input  1  ALU branch-condition result.
REQ-015 imm  input  32  sign-extended immediate of the current instruction.
REQ-016 alu_result  input  32  JALR target (rs1 + imm).
REQ-017 misaligned  output  1  sticky flag: computed next PC had bit 1 set.

Function
REQ-018 The FSM SHALL have states IDLE, FETCH, HOLD and HALT.
REQ-019 IDLE SHALL go to FETCH unconditionally on the next clock.
REQ-020 In FETCH: imem_req=1, imem_addr=pc; on imem_rvalid=1 -> capture imem_rdata into instr, go to HOLD.
REQ-021 imem_req and imem_addr SHALL be driven combinationally from state and pc; a same-cycle imem_rvalid SHALL be accepted, giving minimum latency FETCH->HOLD of 1 clock.
REQ-022 imem_rvalid SHALL be ignored in IDLE, HOLD and HALT.
REQ-023 In HOLD: instr_valid=1; instr and pc SHALL stay stable until instr_ready=1.
REQ-024 Retire = HOLD & instr_ready; only on retire SHALL Branch/Jump/Jalr/zero/imm/alu_result be sampled.
REQ-025 Next PC priority on retire: Jalr -> alu_result & ~32'h1; else Jump -> pc+imm; else Branch & zero -> pc+imm; else pc+4.
REQ-026 All PC arithmetic SHALL be 32-bit modulo 2^32 (wrap, no flag).
REQ-027 On retire with next_pc[1:0]==2'b00: pc <= next_pc, go to FETCH.
REQ-028 On retire with next_pc[1]==1: pc unchanged, misaligned <= 1, go to HALT.
REQ-029 HALT SHALL be absorbing until reset: imem_req=0, instr_valid=0.
REQ-030 instr_valid SHALL be 0 in IDLE, FETCH and HALT.
REQ-031 pc_plus4 SHALL equal pc + 4 combinationally in every state.
REQ-032 Branch and Jump both set: Jump wins; Jalr with Branch or Jump set: Jalr wins.

Reset
REQ-033 rst=1 SHALL immediately force: state=IDLE, pc=RESET_PC, instr=32'h0000_0013 (NOP), misaligned=0, imem_req=0, instr_valid=0.
REQ-034 Reset asserted mid-fetch or in HOLD SHALL abandon the in-flight fetch; the first request after deassert SHALL be at RESET_PC.
REQ-035 First imem_req=1 SHALL appear in the second rising edge after rst deasserts (IDLE then FETCH).

Verification
REQ-036 Sequential: 0-wait memory, instr_ready=1, no control -> pc sequence 0,4,8,12, one instr every 2 clocks.
REQ-037 Wait states: imem_rvalid delayed 3 cycles at pc=0x10 -> imem_req held 4 cycles with imem_addr=0x10, instr_valid low throughout.
REQ-038 Branch: pc=0x20, Branch=1, zero=1, imm=-8 -> next fetch 0x18; same with zero=0 -> 0x24.
REQ-039 JALR: pc=0x40, Jalr=1, Jump=1, alu_result=0x101 -> next fetch 0x100; pc_plus4=0x44 during HOLD.
REQ-040 Misaligned: Jump=1, imm=0x6 at pc=0x0 -> misaligned=1, HALT, imem_req stays 0 for 10 cycles.
REQ-041 Back-pressure and reset: instr_ready=0 for 5 cycles holds instr/pc stable; rst pulse during HOLD -> next fetch at RESET_PC, misaligned=0.

Source files
------------

// File: rtl/pc_fetch_unit.sv
// -----------------------------------------------------------------------------
// pc_fetch_unit
//
// Program-counter and instruction-fetch sequencer for a simple in-order
// RV32-style core. It issues one fetch at a time to instruction memory, holds
// the returned word for the datapath until it is retired, and then computes
// the next PC from the control-unit decode (branch, jump, jalr). A next PC
// with bit 1 set is treated as a fatal misaligned fetch: the unit raises a
// sticky flag and parks in HALT until reset.
//
// Parameters
//   RESET_PC     address of the first instruction fetched after reset
//
// Ports
//   clk          rising-edge clock for all state
//   rst          asynchronous, active-high reset
//   imem_req     fetch request to instruction memory (high only in FETCH)
//   imem_addr    fetch byte address (always the current pc)
//   imem_rvalid  instruction memory returns data this cycle
//   imem_rdata   returned instruction word
//   instr        held instruction; instr[6:0] feeds the control unit
//   instr_valid  instr and pc are valid for execution (high only in HOLD)
//   instr_ready  datapath retires the current instruction this cycle
//   pc           address of the instruction presented on instr
//   pc_plus4     pc + 4, link value for JAL/JALR
//   Branch       current instruction is a conditional branch
//   Jump         current instruction is JAL
//   Jalr         current instruction is JALR
//   zero         ALU branch-condition result
//   imm          sign-extended immediate of the current instruction
//   alu_result   JALR target (rs1 + imm)
//   misaligned   sticky: a computed next PC had bit 1 set
// -----------------------------------------------------------------------------
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  input  logic        Branch,
  input  logic        Jump,
  input  logic        Jalr,
  input  logic        zero,
  input  logic [31:0] imm,
  input  logic [31:0] alu_result,
  output logic        misaligned
);

  localparam logic [31:0] NOP = 32'h0000_0013;  // addi x0, x0, 0

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    HALT  = 2'd3
  } state_t;

  state_t      state;
  logic [31:0] next_pc;
  logic [31:0] pc_plus_imm;
  logic        retire;

  // ---------------------------------------------------------------------------
  // Next-PC selection. Only meaningful on retire; the register below ignores
  // it otherwise, so the control inputs are effectively sampled only then.
  // Priority: Jalr over Jump over taken Branch over sequential.
  // All additions wrap modulo 2^32 by virtue of the 32-bit result width.
  // ---------------------------------------------------------------------------
  assign pc_plus4    = pc + 32'd4;
  assign pc_plus_imm = pc + imm;
  assign retire      = (state == HOLD) && instr_ready;

  // NOTE: every variable assigned in an always_comb gets a value on every path
  // (here a default first), otherwise synthesis infers a latch.
  always_comb begin
    next_pc = pc_plus4;
    if (Jalr) begin
      next_pc = alu_result & ~32'h1;
    end else if (Jump) begin
      next_pc = pc_plus_imm;
    end else if (Branch && zero) begin
      next_pc = pc_plus_imm;
    end
    // Bit 0 of a branch/jump target is architecturally zero (offsets are in
    // multiples of two), so it is dropped rather than treated as a fault.
    // Only bit 1 distinguishes a fetchable target from a misaligned one.
    next_pc[0] = 1'b0;
  end

  // ---------------------------------------------------------------------------
  // Memory-side outputs are combinational from state and pc so that a
  // same-cycle imem_rvalid completes the fetch in a single clock.
  // instr_valid is a pure decode of the state register, so it is glitch-free
  // and drops to 0 the instant reset asserts.
  // ---------------------------------------------------------------------------
  assign imem_req    = (state == FETCH);
  assign imem_addr   = pc;
  assign instr_valid = (state == HOLD);

  // ---------------------------------------------------------------------------
  // Fetch FSM together with pc, instr and the sticky misaligned flag.
  // imem_rvalid is only looked at in FETCH; a stray response in any other
  // state cannot disturb the held instruction.
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      pc         <= RESET_PC;
      instr      <= NOP;
      misaligned <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          state <= FETCH;
        end

        FETCH: begin
          if (imem_rvalid) begin
            instr <= imem_rdata;
            state <= HOLD;
          end
        end

        HOLD: begin
          if (retire) begin
            if (next_pc[1]) begin
              // pc keeps the address of the offending instruction.
              misaligned <= 1'b1;
              state      <= HALT;
            end else begin
              pc    <= next_pc;
              state <= FETCH;
            end
          end
        end

        HALT: begin
          state <= HALT;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Protocol invariants.
  // ---------------------------------------------------------------------------
  hold_stable_a : assert property (
    @(posedge clk) disable iff (rst)
    (state == HOLD && !instr_ready) |=> (state == HOLD && $stable(instr) && $stable(pc))
  );

  halt_absorbing_a : assert property (
    @(posedge clk) disable iff (rst)
    (state == HALT) |=> (state == HALT && misaligned)
  );

endmodule
